if_fetch: RTL and testbench

- Instruction-fetch stage: owns the PC and assembles 32-bit instructions from the byte-wide memory controller port.
- Drives the IF side of the IF/ID pipeline register (if_pc/if_ins) and obeys the same stall/clear controls.
- Presents a NOP bubble whenever no complete instruction is available.
- Accepts branch/jump redirects from EX.

---
 rtl/if_fetch_pkg.sv | 24 ++
 rtl/if_fetch_icache.sv | 51 +++++
 rtl/if_fetch.sv | 146 ++++++++++++++
 tb/tb_if_fetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants, control polarities and fetch state encoding for the IF stage.
// The optional instruction cache is selected with the ICACHE_EN macro.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_FLUSH   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_PC       = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INS      = 32'h0000_0013;
    localparam int          DEF_ICACHE_LINES = 64;

    localparam logic RST_ACTIVE   = 1'b0;
    localparam logic STALL_ACTIVE = 1'b1;
    localparam logic CLEAR_ACTIVE = 1'b1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache for the IF stage: combinational lookup, fill on the
// 4th byte of a missed word. Compiled only when ICACHE_EN is defined.
`ifdef ICACHE_EN
module if_icache #(
    parameter int LINES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:2] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_ins,
    input  logic        fill_en,
    input  logic [31:2] fill_pc,
    input  logic [31:0] fill_ins
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] lookup_idx, fill_idx;
    logic [TAG_W-1:0] lookup_tag, fill_tag;

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign lookup_tag = lookup_pc[31:IDX_W+2];
    assign fill_idx   = fill_pc[IDX_W+1:2];
    assign fill_tag   = fill_pc[31:IDX_W+2];

    assign hit     = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign hit_ins = data_q[lookup_idx];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage needs no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_ins;
        end
    end

endmodule
`endif

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, assembles 32-bit words from a byte-wide memory port
// and drives the IF side of IF/ID. Define ICACHE_EN to add a direct-mapped instruction cache.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
    parameter logic [31:0] NOP_PC       = DEF_NOP_PC,
    parameter logic [31:0] NOP_INS      = DEF_NOP_INS,
    parameter int          ICACHE_LINES = DEF_ICACHE_LINES
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        stall,
    input  logic        clear,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_ins
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [23:0]  buf_q, buf_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_ins_q, if_ins_d;

    logic        stall_on, redirect, fetching, cache_hit;
    logic [31:0] cache_ins, full_word;

    assign stall_on  = (stall == STALL_ACTIVE);
    assign redirect  = jump_en || (clear == CLEAR_ACTIVE);
    assign fetching  = (state_q == ST_FETCH);
    assign full_word = {mem_data, buf_q};

`ifdef ICACHE_EN
    logic lookup_hit, fill_en;

    if_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .lookup_pc (pc_q[31:2]),
        .hit       (lookup_hit),
        .hit_ins   (cache_ins),
        .fill_en   (fill_en),
        .fill_pc   (pc_q[31:2]),
        .fill_ins  (full_word)
    );

    assign cache_hit = fetching && (byte_cnt_q == 2'd0) && lookup_hit;
    assign fill_en   = rdy_in && fetching && !redirect && !cache_hit
                       && mem_valid && (byte_cnt_q == 2'd3);
`else
    assign cache_hit = 1'b0;
    assign cache_ins = NOP_INS;
`endif

    // Request is held off during reset and whenever the cache can supply the word.
    assign mem_req  = (rst_in != RST_ACTIVE) && fetching && !cache_hit;
    assign mem_addr = pc_q + {30'd0, byte_cnt_q};
    assign if_pc    = if_pc_q;
    assign if_ins   = if_ins_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_ins_d   = if_ins_q;

        if (redirect) begin
            // A byte still in flight may come back next cycle, so a live request goes via FLUSH.
            if (jump_en) begin
                pc_d = word_align(jump_target);
            end
            byte_cnt_d = 2'd0;
            if_pc_d    = NOP_PC;
            if_ins_d   = NOP_INS;
            state_d    = mem_req ? ST_FLUSH : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (cache_hit) begin
                        if_pc_d  = pc_q;
                        if_ins_d = cache_ins;
                        state_d  = ST_PRESENT;
                    end else if (mem_valid) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: buf_d[7:0]   = mem_data;
                            2'd1: buf_d[15:8]  = mem_data;
                            2'd2: buf_d[23:16] = mem_data;
                            default: begin
                                if_pc_d  = pc_q;
                                if_ins_d = full_word;
                                state_d  = ST_PRESENT;
                            end
                        endcase
                    end
                end
                ST_PRESENT: begin
                    if (!stall_on) begin
                        pc_d     = pc_q + 32'd4;
                        if_pc_d  = NOP_PC;
                        if_ins_d = NOP_INS;
                        state_d  = ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_FETCH;
                end
                default: begin
                    byte_cnt_d = 2'd0;
                    if_pc_d    = NOP_PC;
                    if_ins_d   = NOP_INS;
                    state_d    = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            byte_cnt_q <= 2'd0;
            buf_q      <= 24'd0;
            if_pc_q    <= NOP_PC;
            if_ins_q   <= NOP_INS;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            if_pc_q    <= if_pc_d;
            if_ins_q   <= if_ins_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized self-checking bench for if_fetch: a byte-memory responder plus a
// transaction-level reference model of the fetch stage (cache modelled when ICACHE_EN is set).
module tb_if_fetch;

    localparam logic [31:0] NOP_INS = 32'h0000_0013;
    localparam logic [31:0] NOP_PC  = 32'h0000_0000;
    localparam int          LINES   = 64;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        stall = 1'b0;
    logic        clear = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_data = 8'd0;
    logic        mem_req;
    logic [31:0] mem_addr, if_pc, if_ins;

    if_fetch dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .stall       (stall),
        .clear       (clear),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .if_pc       (if_pc),
        .if_ins      (if_ins)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: fetch pc, bytes collected so far, presented word, flush pending.
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_ipc = 32'd0;
    logic [31:0] m_ins = 32'd0;
    bit          m_show = 1'b0;
    bit          m_flush = 1'b0;
    logic [7:0]  got [$];
    logic [31:0] c_pc  [int];
    logic [31:0] c_ins [int];

    // Memory responder state.
    bit          busy = 1'b0;
    bit          req_prev = 1'b0;
    int          cnt = 0;
    logic [31:0] busy_addr = 32'd0;
    int          lat_lo = 0;
    int          lat_hi = 3;
    int          stale_pct = 50;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h00;
            32'd3:   return 8'h00;
            default: begin
                h = a * 32'h9E37_79B1;
                return h[31:24] ^ h[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    function automatic int cidx(input logic [31:0] pc);
        return int'((pc >> 2) % LINES);
    endfunction

    function automatic bit model_hit();
`ifdef ICACHE_EN
        return (got.size() == 0) && c_pc.exists(cidx(m_pc)) && (c_pc[cidx(m_pc)] == m_pc);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_req();
        return !m_show && !m_flush && !model_hit();
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic deliver(input logic [31:0] a);
        mem_valid = 1'b1;
        mem_data  = mem_byte(a);
    endtask

    // One cycle: check outputs, drive controls, run the memory, advance the model.
    task automatic applyStimulus(input bit r, input bit s, input bit c, input bit j,
                                 input logic [31:0] t);
        bit er;
        int k;
        int idx;
        er = model_req();
        checkOutput("mem_req", {31'd0, mem_req}, {31'd0, er});
        if (er) checkOutput("mem_addr", mem_addr, m_pc + 32'(got.size()));
        checkOutput("if_pc", if_pc, m_show ? m_ipc : NOP_PC);
        checkOutput("if_ins", if_ins, m_show ? m_ins : NOP_INS);

        rdy_in = r; stall = s; clear = c; jump_en = j; jump_target = t;
        mem_valid = 1'b0;
        mem_data  = 8'($urandom);
        if (r) begin
            if (busy) begin
                if (!mem_req) begin
                    if (req_prev && ($urandom_range(99, 0) < stale_pct)) deliver(busy_addr);
                    busy = 1'b0;
                end else if (cnt == 0) begin
                    deliver(busy_addr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_req) begin
                k = $urandom_range(lat_hi, lat_lo);
                busy_addr = mem_addr;
                if (k == 0) deliver(busy_addr);
                else begin
                    busy = 1'b1;
                    cnt = k - 1;
                end
            end
            req_prev = mem_req;

            idx = cidx(m_pc);
            if (j || c) begin
                if (j) m_pc = t & ~32'd3;
                got.delete();
                m_show  = 1'b0;
                m_flush = er;
            end else if (m_flush) begin
                m_flush = 1'b0;
            end else if (m_show) begin
                if (!s) begin
                    m_show = 1'b0;
                    m_pc   = m_pc + 32'd4;
                end
            end else if (model_hit()) begin
                m_show = 1'b1;
                m_ipc  = m_pc;
                m_ins  = c_ins[idx];
            end else if (mem_valid) begin
                got.push_back(mem_data);
                if (got.size() == 4) begin
                    m_ins  = {got[3], got[2], got[1], got[0]};
                    m_ipc  = m_pc;
                    m_show = 1'b1;
                    c_pc[idx]  = m_pc;
                    c_ins[idx] = m_ins;
                    got.delete();
                end
            end
        end
        @(negedge clk_in);
    endtask

    task automatic stepIdle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic runUntilShow(input string tag);
        for (int i = 0; i < 60 && !m_show; i++) stepIdle();
        checkOutput(tag, {31'd0, m_show}, 32'd1);
    endtask

    task automatic runUntilBytes(input int n, input string tag);
        for (int i = 0; i < 60 && got.size() != n; i++) stepIdle();
        checkOutput(tag, 32'(got.size()), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] saved_pc, saved_ins, saved_addr;
        bit r, s, c, j;
        logic [31:0] t;

        #2 rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_if_pc", if_pc, NOP_PC);
        checkOutput("reset_if_ins", if_ins, NOP_INS);
        rst_in = 1'b1;
        @(negedge clk_in);

        $display("[TB] first fetch from reset");
        runUntilShow("t1_timeout");
        checkOutput("t1_pc", if_pc, 32'h0000_0000);
        checkOutput("t1_ins", if_ins, 32'h0000_0513);
        stepIdle();
        checkOutput("t1_next_addr", mem_addr, 32'h0000_0004);

        $display("[TB] stall while presenting");
        runUntilShow("t2_timeout");
        saved_pc  = if_pc;
        saved_ins = if_ins;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_hold_ins", if_ins, saved_ins);
        stepIdle();
        checkOutput("t2_next_addr", mem_addr, saved_pc + 32'd4);

        $display("[TB] redirect mid-word with stale byte");
        lat_lo = 1; lat_hi = 1; stale_pct = 100;
        runUntilBytes(2, "t3_bytes_timeout");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1002);
        checkOutput("t3_flush_req", {31'd0, mem_req}, 32'd0);
        checkOutput("t3_bubble", if_ins, NOP_INS);
        stepIdle();
        checkOutput("t3_target_addr", mem_addr, 32'h0000_1000);
        runUntilShow("t3_timeout");
        checkOutput("t3_pc", if_pc, 32'h0000_1000);
        checkOutput("t3_ins", if_ins, mem_word(32'h0000_1000));

        $display("[TB] pc wrap-around");
        lat_lo = 0; lat_hi = 3; stale_pct = 50;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        runUntilShow("t4_timeout");
        checkOutput("t4_pc", if_pc, 32'hFFFF_FFFC);
        checkOutput("t4_ins", if_ins, mem_word(32'hFFFF_FFFC));
        stepIdle();
        checkOutput("t4_wrap_addr", mem_addr, 32'h0000_0000);

        $display("[TB] rdy_in low mid-fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
        runUntilBytes(1, "t5_bytes_timeout");
        saved_addr = mem_addr;
        repeat (5) applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        checkOutput("t5_frozen_addr", mem_addr, saved_addr);
        runUntilShow("t5_timeout");
        checkOutput("t5_pc", if_pc, 32'h0000_2000);

`ifdef ICACHE_EN
        $display("[TB] cached loop at 0x100");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        runUntilShow("t6_first_timeout");
        stepIdle();
        runUntilShow("t6_second_timeout");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        checkOutput("t6_hit0_req", {31'd0, mem_req}, 32'd0);
        stepIdle();
        checkOutput("t6_hit0_pc", if_pc, 32'h0000_0100);
        checkOutput("t6_hit0_ins", if_ins, mem_word(32'h0000_0100));
        stepIdle();
        checkOutput("t6_hit1_req", {31'd0, mem_req}, 32'd0);
        stepIdle();
        checkOutput("t6_hit1_pc", if_pc, 32'h0000_0104);
        checkOutput("t6_hit1_ins", if_ins, mem_word(32'h0000_0104));
`endif

        $display("[TB] random phase");
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(99, 0) < 90);
            s = ($urandom_range(99, 0) < 30);
            c = ($urandom_range(99, 0) < 3);
            j = ($urandom_range(99, 0) < 4);
            if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else t = 32'($urandom_range(32'h3FF, 0));
            applyStimulus(r, s, c, j, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
